// File: rtl/router_pkg.sv
`default_nettype none
// ============================================================================
// Module      : router_pkg
// Description : Shared types, default widths and helpers for the router
//               input-port receiver.
// Revision    : 1.0 - initial release
// ============================================================================
package router_pkg;

    // Receive FSM state encoding
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ADDR  = 3'd1,
        PAD   = 3'd2,
        DATA  = 3'd3,
        FLUSH = 3'd4,
        SKIP  = 3'd5
    } rx_state_e;

    localparam int DEF_ADDR_W     = 4;
    localparam int DEF_DATA_W     = 8;
    localparam int DEF_PAD_CYCLES = 5;
    localparam int DEF_DEPTH      = 4;
    localparam int DEF_CNT_W      = 8;

    // Widest word the partial-word helper supports
    localparam int MAX_DATA_W     = 64;

    // Keep only the low nbits of a word (bits not yet received read as zero)
    function automatic logic [MAX_DATA_W-1:0] zext_partial(
        input logic [MAX_DATA_W-1:0] word,
        input int                    nbits
    );
        logic [MAX_DATA_W-1:0] mask;
        mask = '0;
        for (int i = 0; i < MAX_DATA_W; i++) begin
            if (i < nbits) mask[i] = 1'b1;
        end
        return word & mask;
    endfunction

endpackage
`default_nettype wire

// File: rtl/router_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : router_rx_fifo
// Description : Synchronous first-word-fall-through FIFO. o_rdata shows the
//               head entry whenever o_empty is low (zero when empty). A push
//               while full is accepted if a pop happens in the same cycle.
// Ports       : clk, i_rst_n (async active-low), i_push/i_wdata,
//               i_pop, o_rdata, o_full, o_empty
// Revision    : 1.0 - initial release
// ============================================================================
module router_rx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             i_rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_full,
    output logic             o_empty
);

    localparam int PW = $clog2(DEPTH);

    // Pointers carry one extra wrap bit to tell full from empty
    logic [PW:0]      r_wr_ptr;
    logic [PW:0]      r_rd_ptr;
    logic [WIDTH-1:0] r_mem [DEPTH];

    logic w_empty;
    logic w_full;
    logic w_do_pop;
    logic w_do_push;

    assign w_empty   = (r_wr_ptr == r_rd_ptr);
    assign w_full    = (r_wr_ptr[PW] != r_rd_ptr[PW]) &&
                       (r_wr_ptr[PW-1:0] == r_rd_ptr[PW-1:0]);
    assign w_do_pop  = i_pop && !w_empty;
    assign w_do_push = i_push && (!w_full || w_do_pop);

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // Storage needs no reset: contents are only visible when non-empty
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr[PW-1:0]] <= i_wdata;
    end

    assign o_rdata = w_empty ? '0 : r_mem[r_rd_ptr[PW-1:0]];
    assign o_full  = w_full;
    assign o_empty = w_empty;

endmodule
`default_nettype wire

// File: rtl/router_rx_port.sv
`default_nettype none
// ============================================================================
// Module      : router_rx_port
// Description : Serial router input-port receiver. Parses address, pad and
//               data phases (LSB first) and emits DATA_W-bit words tagged
//               with address/sop/eop/err on a ready/valid stream through a
//               FWFT buffer. Counts words lost to a full buffer.
// Ports       : clk, reset_n (async active-low)
//               din, valid_n, frame_n          - serial input
//               m_valid/m_ready, m_data, m_addr,
//               m_sop, m_eop, m_err            - output word stream
//               busy                           - FSM not idle
//               drop_cnt                       - saturating drop counter
// Revision    : 1.0 - initial release
// ============================================================================
module router_rx_port
    import router_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DATA_W     = DEF_DATA_W,      // at most MAX_DATA_W
    parameter int PAD_CYCLES = DEF_PAD_CYCLES,
    parameter int DEPTH      = DEF_DEPTH,
    parameter int CNT_W      = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              din,
    input  logic              valid_n,
    input  logic              frame_n,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic [ADDR_W-1:0] m_addr,
    output logic              m_sop,
    output logic              m_eop,
    output logic              m_err,
    output logic              busy,
    output logic [CNT_W-1:0]  drop_cnt
);

    localparam int ADDR_CW = (ADDR_W > 1)     ? $clog2(ADDR_W)     : 1;
    localparam int BIT_CW  = (DATA_W > 1)     ? $clog2(DATA_W)     : 1;
    localparam int PAD_CW  = (PAD_CYCLES > 1) ? $clog2(PAD_CYCLES) : 1;
    localparam int FW      = DATA_W + ADDR_W + 3;

    localparam logic [ADDR_CW-1:0] ADDR_LAST = ADDR_CW'(ADDR_W - 1);
    localparam logic [BIT_CW-1:0]  BIT_LAST  = BIT_CW'(DATA_W - 1);
    localparam logic [PAD_CW-1:0]  PAD_LAST  =
        PAD_CW'((PAD_CYCLES > 0) ? PAD_CYCLES - 1 : 0);
    localparam rx_state_e AFTER_ADDR = (PAD_CYCLES > 0) ? PAD : DATA;

    rx_state_e           r_state;
    logic [ADDR_W-1:0]   r_addr;
    logic [ADDR_CW-1:0]  r_addrcnt;
    logic [PAD_CW-1:0]   r_padcnt;
    logic [DATA_W-1:0]   r_shift;
    logic [BIT_CW-1:0]   r_bitcnt;
    logic                r_err;      // packet already known bad
    logic                r_first;    // next word is the first of the packet
    logic                r_seen;     // FLUSH saw a new packet start
    logic [CNT_W-1:0]    r_drop;

    logic                w_sample;
    logic [DATA_W-1:0]   w_word;
    logic [DATA_W-1:0]   w_partial;
    logic                w_complete;
    logic                w_pending;
    int                  w_nbits;
    logic                w_want;
    logic [DATA_W-1:0]   w_pdata;
    logic                w_psop;
    logic                w_peop;
    logic                w_perr;
    logic                w_push;
    logic                w_pop;
    logic                w_space;
    logic                w_drop;
    logic                w_seen;
    logic [CNT_W-1:0]    w_drop_inc;
    logic                w_full;
    logic                w_empty;
    logic [FW-1:0]       w_rdata;

    // Word including this cycle's bit, if one is sampled
    always_comb begin
        w_word = r_shift;
        if (w_sample) w_word[r_bitcnt] = din;
    end

    assign w_sample   = !valid_n;
    assign w_complete = w_sample && (r_bitcnt == BIT_LAST);
    assign w_pending  = w_sample || (r_bitcnt != '0);
    assign w_nbits    = int'(r_bitcnt) + (w_sample ? 1 : 0);
    assign w_partial  = DATA_W'(zext_partial(MAX_DATA_W'(w_word), w_nbits));
    assign w_seen     = r_seen || !frame_n;
    assign w_drop_inc = (r_drop == '1) ? r_drop : r_drop + 1'b1;

    // Word to push this cycle, if any
    always_comb begin
        w_want  = 1'b0;
        w_pdata = '0;
        w_psop  = 1'b0;
        w_peop  = 1'b0;
        w_perr  = 1'b0;
        case (r_state)
            DATA: begin
                w_psop = r_first;
                if (frame_n) begin
                    w_want = 1'b1;
                    w_peop = 1'b1;
                    if (w_complete) begin
                        w_pdata = w_word;
                        w_perr  = r_err;
                    end else if (w_pending) begin
                        w_pdata = w_partial;
                        w_perr  = 1'b1;
                    end else begin
                        w_pdata = '0;
                        w_perr  = 1'b1;
                    end
                end else if (w_complete) begin
                    w_want  = 1'b1;
                    w_pdata = w_word;
                    w_perr  = r_err;
                end
            end
            FLUSH: begin
                // Terminator for the packet whose eop word was lost
                w_want = 1'b1;
                w_peop = 1'b1;
                w_perr = 1'b1;
            end
            default: ;
        endcase
    end

    assign w_pop   = !w_empty && m_ready;
    assign w_space = !w_full || w_pop;   // a pop frees a slot this cycle
    assign w_push  = w_want && w_space;
    assign w_drop  = w_want && !w_space && (r_state == DATA);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= IDLE;
            r_addr    <= '0;
            r_addrcnt <= '0;
            r_padcnt  <= '0;
            r_shift   <= '0;
            r_bitcnt  <= '0;
            r_err     <= 1'b0;
            r_first   <= 1'b0;
            r_seen    <= 1'b0;
            r_drop    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (!frame_n) begin
                        r_addr    <= ADDR_W'(din);
                        r_addrcnt <= ADDR_CW'(1);
                        r_padcnt  <= '0;
                        r_shift   <= '0;
                        r_bitcnt  <= '0;
                        r_err     <= 1'b0;
                        r_first   <= 1'b1;
                        r_seen    <= 1'b0;
                        r_state   <= (ADDR_W > 1) ? ADDR : AFTER_ADDR;
                    end
                end
                ADDR: begin
                    if (frame_n) begin
                        r_state <= IDLE;
                    end else begin
                        r_addr[r_addrcnt] <= din;
                        r_addrcnt         <= r_addrcnt + 1'b1;
                        if (r_addrcnt == ADDR_LAST) r_state <= AFTER_ADDR;
                    end
                end
                PAD: begin
                    if (frame_n) begin
                        r_state <= IDLE;
                    end else begin
                        if (!valid_n) r_err <= 1'b1;
                        r_padcnt <= r_padcnt + 1'b1;
                        if (r_padcnt == PAD_LAST) r_state <= DATA;
                    end
                end
                DATA: begin
                    if (w_complete || frame_n) begin
                        r_shift  <= '0;
                        r_bitcnt <= '0;
                    end else if (w_sample) begin
                        r_shift  <= w_word;
                        r_bitcnt <= r_bitcnt + 1'b1;
                    end
                    if (w_want) r_first <= 1'b0;
                    if (w_drop) begin
                        r_err  <= 1'b1;
                        r_drop <= w_drop_inc;
                    end
                    if (frame_n) r_state <= w_drop ? FLUSH : IDLE;
                end
                FLUSH: begin
                    if (w_push) begin
                        r_seen <= 1'b0;
                        // A packet that started while flushing cannot be
                        // parsed from its middle; skip it and count it lost
                        if (w_seen) begin
                            r_state <= SKIP;
                            r_drop  <= w_drop_inc;
                        end else begin
                            r_state <= IDLE;
                        end
                    end else begin
                        r_seen <= w_seen;
                    end
                end
                SKIP: begin
                    if (frame_n && !valid_n) r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    router_rx_fifo #(
        .WIDTH (FW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .i_rst_n (reset_n),
        .i_push  (w_push),
        .i_wdata ({w_pdata, r_addr, w_psop, w_peop, w_perr}),
        .i_pop   (w_pop),
        .o_rdata (w_rdata),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign m_valid  = !w_empty;
    assign m_data   = w_rdata[FW-1 -: DATA_W];
    assign m_addr   = w_rdata[ADDR_W+2 : 3];
    assign m_sop    = w_rdata[2];
    assign m_eop    = w_rdata[1];
    assign m_err    = w_rdata[0];
    assign busy     = (r_state != IDLE);
    assign drop_cnt = r_drop;

endmodule
`default_nettype wire

// File: tb/tb_router_rx_port.sv
`default_nettype none
// ============================================================================
// Module      : tb_router_rx_port
// Description : Self-checking bench for router_rx_port with default
//               parameters. Expected words are queued as packets are driven
//               and compared as the DUT hands them over.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_router_rx_port;

    localparam int ADDR_W     = 4;
    localparam int DATA_W     = 8;
    localparam int PAD_CYCLES = 5;
    localparam int DEPTH      = 4;
    localparam int CNT_W      = 8;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              din;
    logic              valid_n;
    logic              frame_n;
    logic              m_valid;
    logic              m_ready;
    logic [DATA_W-1:0] m_data;
    logic [ADDR_W-1:0] m_addr;
    logic              m_sop;
    logic              m_eop;
    logic              m_err;
    logic              busy;
    logic [CNT_W-1:0]  drop_cnt;

    router_rx_port #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .PAD_CYCLES (PAD_CYCLES),
        .DEPTH      (DEPTH),
        .CNT_W      (CNT_W)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .din      (din),
        .valid_n  (valid_n),
        .frame_n  (frame_n),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .m_data   (m_data),
        .m_addr   (m_addr),
        .m_sop    (m_sop),
        .m_eop    (m_eop),
        .m_err    (m_err),
        .busy     (busy),
        .drop_cnt (drop_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] d;
        logic [3:0] a;
        logic       sop;
        logic       eop;
        logic       err;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    exp_t mon_exp;
    exp_t mon_got;

    function automatic exp_t mk(input logic [7:0] d, input logic [3:0] a,
                                input logic s, input logic e, input logic r);
        exp_t x;
        x.d = d; x.a = a; x.sop = s; x.eop = e; x.err = r;
        return x;
    endfunction

    // Output monitor: a transfer completes at the next rising edge
    always @(negedge clk) begin
        if (reset_n && m_valid && m_ready) begin
            n_checks++;
            mon_got = {m_data, m_addr, m_sop, m_eop, m_err};
            if (sb.size() == 0) begin
                $display("FAIL out_unexpected: got d=%h a=%h sop=%b eop=%b err=%b, expected no word",
                         m_data, m_addr, m_sop, m_eop, m_err);
            end else begin
                mon_exp = sb.pop_front();
                if (mon_got !== mon_exp)
                    $display("FAIL out_word: got d=%h a=%h sop=%b eop=%b err=%b, expected d=%h a=%h sop=%b eop=%b err=%b",
                             m_data, m_addr, m_sop, m_eop, m_err,
                             mon_exp.d, mon_exp.a, mon_exp.sop, mon_exp.eop, mon_exp.err);
                else
                    n_pass++;
            end
        end
    end

    task automatic drive(input logic f, input logic v, input logic d);
        frame_n = f;
        valid_n = v;
        din     = d;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b1, 1'b1, 1'b0);
    endtask

    task automatic send_hdr(input logic [3:0] a, input logic pad_err);
        for (int i = 0; i < ADDR_W; i++) drive(1'b0, 1'b1, a[i]);
        for (int i = 0; i < PAD_CYCLES; i++)
            drive(1'b0, (pad_err && i == 2) ? 1'b0 : 1'b1, 1'b0);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic last, input logic gaps);
        for (int i = 0; i < 8; i++) begin
            if (gaps && (i == 2 || i == 5 || i == 7)) begin
                int g;
                g = $urandom_range(1, 3);
                for (int k = 0; k < g; k++) drive(1'b0, 1'b1, 1'b1);
            end
            drive((last && i == 7) ? 1'b1 : 1'b0, 1'b0, b[i]);
        end
    endtask

    task automatic wait_drain(input string name);
        int t;
        t = 0;
        while (sb.size() != 0 && t < 200) begin
            @(posedge clk);
            #1;
            t++;
        end
        n_checks++;
        if (sb.size() != 0)
            $display("FAIL %s_drain: %0d words still expected, required 0", name, sb.size());
        else
            n_pass++;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        frame_n = 1'b1;
        valid_n = 1'b1;
        din     = 1'b0;
        m_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (m_valid !== 1'b0) $display("FAIL rst_valid: got %b, required 0", m_valid);
        else n_pass++;
        n_checks++;
        if (busy !== 1'b0) $display("FAIL rst_busy: got %b, required 0", busy);
        else n_pass++;
        n_checks++;
        if (drop_cnt !== '0) $display("FAIL rst_drop: got %0d, required 0", drop_cnt);
        else n_pass++;
        n_checks++;
        if ({m_data, m_addr, m_sop, m_eop, m_err} !== '0)
            $display("FAIL rst_outs: got %h, required 0", {m_data, m_addr, m_sop, m_eop, m_err});
        else n_pass++;
        reset_n = 1'b1;
        idle(2);
    endtask

    task automatic test_basic();
        logic [7:0] bytes [2];
        bytes[0] = 8'h5A;
        bytes[1] = 8'hC3;
        m_ready = 1'b1;
        sb.push_back(mk(8'h5A, 4'hA, 1'b1, 1'b0, 1'b0));
        sb.push_back(mk(8'hC3, 4'hA, 1'b0, 1'b1, 1'b0));
        send_hdr(4'hA, 1'b0);
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 8; i++) begin
                if (i == 7) begin
                    n_checks++;
                    if (m_valid !== 1'b0) $display("FAIL basic_pre_valid: got %b, required 0", m_valid);
                    else n_pass++;
                end
                drive((k == 1 && i == 7) ? 1'b1 : 1'b0, 1'b0, bytes[k][i]);
                if (i == 7) begin
                    n_checks++;
                    if (m_valid !== 1'b1) $display("FAIL basic_latency: got m_valid=%b, required 1", m_valid);
                    else n_pass++;
                end
            end
        end
        n_checks++;
        if (busy !== 1'b0) $display("FAIL basic_busy_end: got %b, required 0", busy);
        else n_pass++;
        idle(2);
        wait_drain("basic");
    endtask

    task automatic test_gaps();
        m_ready = 1'b1;
        sb.push_back(mk(8'h5A, 4'hA, 1'b1, 1'b0, 1'b0));
        sb.push_back(mk(8'hC3, 4'hA, 1'b0, 1'b1, 1'b0));
        send_hdr(4'hA, 1'b0);
        send_byte(8'h5A, 1'b0, 1'b1);
        send_byte(8'hC3, 1'b1, 1'b1);
        idle(2);
        wait_drain("gaps");
    endtask

    task automatic test_malformed();
        m_ready = 1'b1;
        // partial tail: bits 1,0,1 -> 0x05
        sb.push_back(mk(8'h11, 4'h5, 1'b1, 1'b0, 1'b0));
        sb.push_back(mk(8'h05, 4'h5, 1'b0, 1'b1, 1'b1));
        send_hdr(4'h5, 1'b0);
        send_byte(8'h11, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b1);
        idle(2);
        wait_drain("partial");
        // empty end: frame ends with no bit sampled
        sb.push_back(mk(8'h33, 4'h2, 1'b1, 1'b0, 1'b0));
        sb.push_back(mk(8'h00, 4'h2, 1'b0, 1'b1, 1'b1));
        send_hdr(4'h2, 1'b0);
        send_byte(8'h33, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b0);
        idle(2);
        wait_drain("empty_end");
    endtask

    task automatic test_pad();
        m_ready = 1'b1;
        for (int i = 0; i < ADDR_W; i++) drive(1'b0, 1'b1, 1'b0);
        drive(1'b0, 1'b1, 1'b0);
        drive(1'b0, 1'b1, 1'b0);
        n_checks++;
        if (busy !== 1'b1) $display("FAIL pad_busy: got %b, required 1", busy);
        else n_pass++;
        drive(1'b1, 1'b1, 1'b0);
        n_checks++;
        if (busy !== 1'b0) $display("FAIL abort_busy: got %b, required 0", busy);
        else n_pass++;
        idle(4);
        n_checks++;
        if (m_valid !== 1'b0) $display("FAIL abort_valid: got %b, required 0", m_valid);
        else n_pass++;
        n_checks++;
        if (drop_cnt !== 8'd0) $display("FAIL abort_drop: got %0d, required 0", drop_cnt);
        else n_pass++;
        // valid_n low during pad marks every word bad
        sb.push_back(mk(8'h21, 4'h9, 1'b1, 1'b0, 1'b1));
        sb.push_back(mk(8'h42, 4'h9, 1'b0, 1'b1, 1'b1));
        send_hdr(4'h9, 1'b1);
        send_byte(8'h21, 1'b0, 1'b0);
        send_byte(8'h42, 1'b1, 1'b0);
        idle(2);
        wait_drain("pad_err");
    endtask

    task automatic test_overflow();
        m_ready = 1'b0;
        for (int i = 1; i <= 4; i++)
            sb.push_back(mk(8'(i), 4'h7, (i == 1), 1'b0, 1'b0));
        sb.push_back(mk(8'h00, 4'h7, 1'b0, 1'b1, 1'b1));
        send_hdr(4'h7, 1'b0);
        for (int i = 1; i <= 6; i++) send_byte(8'(i), (i == 6), 1'b0);
        n_checks++;
        if (drop_cnt !== 8'd2) $display("FAIL ovf_drop: got %0d, required 2", drop_cnt);
        else n_pass++;
        idle(1);
        n_checks++;
        if (busy !== 1'b1) $display("FAIL ovf_flush_busy: got %b, required 1", busy);
        else n_pass++;
        n_checks++;
        if (m_data !== 8'h01) $display("FAIL ovf_head: got %h, required 01", m_data);
        else n_pass++;
        // New packet starts while flushing: it must be skipped and counted
        drive(1'b0, 1'b1, 1'b1);
        drive(1'b0, 1'b1, 1'b1);
        drive(1'b0, 1'b1, 1'b0);
        m_ready = 1'b1;
        drive(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < PAD_CYCLES; i++) drive(1'b0, 1'b1, 1'b0);
        send_byte(8'hEE, 1'b1, 1'b0);
        n_checks++;
        if (drop_cnt !== 8'd3) $display("FAIL skip_drop: got %0d, required 3", drop_cnt);
        else n_pass++;
        n_checks++;
        if (busy !== 1'b0) $display("FAIL skip_busy: got %b, required 0", busy);
        else n_pass++;
        idle(2);
        wait_drain("overflow");
    endtask

    task automatic test_reset_mid();
        m_ready = 1'b0;
        send_hdr(4'h1, 1'b0);
        send_byte(8'h10, 1'b0, 1'b0);
        send_byte(8'h20, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 1'b1);
        n_checks++;
        if (m_valid !== 1'b1) $display("FAIL rm_pre_valid: got %b, required 1", m_valid);
        else n_pass++;
        reset_n = 1'b0;
        #1;
        n_checks++;
        if (m_valid !== 1'b0) $display("FAIL rm_valid: got %b, required 0", m_valid);
        else n_pass++;
        n_checks++;
        if (drop_cnt !== 8'd0) $display("FAIL rm_drop: got %0d, required 0", drop_cnt);
        else n_pass++;
        n_checks++;
        if (busy !== 1'b0) $display("FAIL rm_busy: got %b, required 0", busy);
        else n_pass++;
        frame_n = 1'b1;
        valid_n = 1'b1;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        idle(2);
        n_checks++;
        if (m_valid !== 1'b0) $display("FAIL rm_post_valid: got %b, required 0", m_valid);
        else n_pass++;
        m_ready = 1'b1;
        sb.push_back(mk(8'h7E, 4'h3, 1'b1, 1'b1, 1'b0));
        send_hdr(4'h3, 1'b0);
        send_byte(8'h7E, 1'b1, 1'b0);
        idle(2);
        wait_drain("after_reset");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_gaps();
        test_malformed();
        test_pad();
        test_overflow();
        test_reset_mid();
        idle(3);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1);
    end

endmodule
`default_nettype wire
